ps2_host_tx: RTL and testbench
==============================

Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter. Sends one command byte, such as 0xED (set LEDs), 0xF4 (enable) or 0xFF (reset), from the FPGA to the keyboard.
- Implements the full PS/2 request-to-send sequence: clock inhibit, start bit, 8 data bits LSB first, odd parity, stop bit, then device ACK check.
- Sits beside the existing keyboard receiver on the same PS2_CLK/PS2_DAT pins. Top level drives the pins open-drain from the *_oe outputs.
- `busy` lets the top level gate the receiver while a transmission is in progress.

Parameters:
- INHIBIT_CYCLES, 5000, clock-low hold before the start bit (100 us at 50 MHz).
- REQ_CYCLES, 250, data-low with clock still low before the clock is released (5 us).
- FIRST_CLK_TIMEOUT, 750000, maximum wait from clock release to the first device falling edge (15 ms).
- BIT_TIMEOUT, 100000, maximum gap between successive device falling edges (2 ms).
- FILTER_LEN, 8, number of consecutive equal samples needed to change the filtered PS/2 clock.

Ports:
- CLOCK_50  in  1  system clock, 50 MHz.
- reset  in  1  synchronous, active-high reset.
- tx_data  in  8  command byte to send.
- tx_valid  in  1  request; accepted on the cycle where tx_valid && tx_ready.
- tx_ready  out  1  high only in IDLE.
- ps2_clk_in  in  1  raw PS2_CLK pin value (asynchronous).
- ps2_dat_in  in  1  raw PS2_DAT pin value (asynchronous).
- ps2_clk_oe  out  1  1 = pull PS2_CLK low; 0 = release.
- ps2_dat_oe  out  1  1 = pull PS2_DAT low; 0 = release.
- busy  out  1  high in every state except IDLE.
- tx_done  out  1  one-cycle pulse: byte sent and device ACK seen.
- tx_error  out  1  one-cycle pulse: timeout or missing ACK.

Behaviour:
- All logic is clocked on posedge CLOCK_50. Reset is synchronous.
- Reset values: ps2_clk_oe=0, ps2_dat_oe=0, busy=0, tx_done=0, tx_error=0, tx_ready=1, state=IDLE.
- All outputs are registered.
- Clock input path:
  - ps2_clk_in passes through a 2-FF synchronizer, then a FILTER_LEN-sample filter.
  - A one-cycle `fall` pulse is produced when the filtered clock goes 1->0.
  - Latency from pin edge to `fall`: at most FILTER_LEN+3 cycles.
  - ps2_dat_in uses a 2-FF synchronizer only.
- Accept:
  - On tx_valid && tx_ready, latch tx_data and compute par = ~^tx_data (odd parity).
  - Load shift register {1'b1 stop, par, data[7:0]} and go to INHIBIT.
  - tx_valid is ignored while busy. There is no queueing.
- INHIBIT: clk_oe=1, dat_oe=0, held for INHIBIT_CYCLES, then go to REQ.
- REQ: clk_oe=1, dat_oe=1 (start bit), held for REQ_CYCLES. Then clk_oe=0, load watchdog with FIRST_CLK_TIMEOUT, bitcnt=0, go to SEND.
- SEND:
  - On each `fall`: dat_oe = ~shift[0], shift right, bitcnt++, reload watchdog with BIT_TIMEOUT.
  - Falls 1-8 drive data bits, fall 9 drives parity, fall 10 drives stop (dat_oe=0).
  - After fall 10, go to ACK.
- ACK:
  - dat_oe=0.
  - On the next `fall` (11th), sample synchronized data.
  - 0: go to WAIT_IDLE. 1: go to ERR.
- WAIT_IDLE:
  - Wait until filtered clock=1 and synchronized data=1, then go to DONE.
  - Covered by the BIT_TIMEOUT watchdog.
- DONE: tx_done=1 for one cycle, then go to IDLE.
- ERR:
  - tx_error=1 for one cycle; both oe forced to 0 in the same cycle; then go to IDLE.
- Watchdog:
  - Decrements in SEND, ACK and WAIT_IDLE.
  - Reaching 0 goes to ERR.
  - `fall` in the same cycle as expiry wins: the edge is processed.
- Output rules:
  - clk_oe and dat_oe are never both driven outside REQ/INHIBIT/SEND as specified.
  - clk_oe is never 1 after REQ.
- Reset mid-operation: the next cycle releases both lines, returns to IDLE and sets tx_ready=1. No done/error pulse.
- Counters: 20-bit watchdog and phase counter; 4-bit bitcnt. Counters saturate, never wrap.

Decomposition:
- Shared package ps2_pkg:
  - state enum: IDLE, INHIBIT, REQ, SEND, ACK, WAIT_IDLE, DONE, ERR.
  - command constants: CMD_SET_LEDS=8'hED, CMD_ENABLE=8'hF4, CMD_RESET=8'hFF.
  - response constants: RSP_ACK=8'hFA, RSP_RESEND=8'hFE.
  - break prefix constant 8'hF0.
- Sub-module ps2_clk_filter (synchronizer + filter + fall/rise pulses). It is reusable by a rewritten receiver.

Test Plan:
- Reset held 3 cycles, then released -> clk_oe=0, dat_oe=0, tx_ready=1, busy=0, no pulses.
- Send 0xED; device BFM clocks at 12.5 kHz (4000-cycle period) and gives ACK:
  - clk_oe=1 for exactly 5000 cycles.
  - dat_oe rises at cycle 5000 and clk_oe falls at 5250.
  - BFM samples on rising edges: 1,0,1,1,0,1,1,1, parity 1, stop 1.
  - tx_done pulses once; tx_error stays 0.
- Send 0x01 -> parity bit 0. Send 0x00 -> parity bit 1. Both complete with tx_done.
- No device (pins float high after release) -> tx_error pulses 750000 cycles (±FILTER_LEN+3) after clk_oe falls, both oe=0, tx_ready=1.
- BFM leaves data high on the 11th clock (NACK) -> tx_error pulse, no tx_done.
- BFM stops clocking after the 4th fall -> tx_error after 100000 cycles.
- Reset asserted after the 4th fall -> next cycle both oe=0 and tx_ready=1; a tx_valid pulse asserted mid-transfer produces no second transmission.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter states, keyboard command/response
// bytes and the counter widths used by the host-side PS/2 logic.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    SEND,
    ACK,
    WAIT_IDLE,
    DONE,
    ERR
  } ps2_tx_state_t;

  // Host-to-keyboard commands
  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] CMD_RESET    = 8'hFF;

  // Keyboard responses
  localparam logic [7:0] RSP_ACK      = 8'hFA;
  localparam logic [7:0] RSP_RESEND   = 8'hFE;

  // Scan-code break prefix
  localparam logic [7:0] BREAK_PREFIX = 8'hF0;

  // Watchdog / phase counter and bit counter widths
  localparam int CNT_W    = 20;
  localparam int BITCNT_W = 4;

  // PS/2 frames carry odd parity: the parity bit makes the total count of ones odd
  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// PS/2 clock conditioning: 2-FF synchronizer, FILTER_LEN-sample glitch
// filter, and one-cycle fall/rise pulses on the filtered level.
// Pin edge to fall/rise pulse is FILTER_LEN+3 cycles.
module ps2_clk_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clock50,
  input  logic reset,
  input  logic pin_in,
  output logic level,
  output logic fall,
  output logic rise
);

  logic [1:0]            sync_reg;
  logic [FILTER_LEN-1:0] hist_reg;
  logic [FILTER_LEN-1:0] hist_next;
  logic                  level_reg;
  logic                  level_next;
  logic                  fall_reg;
  logic                  rise_reg;

  // Sample history: newest synchronized sample enters at bit 0
  genvar gi;
  generate
    for (gi = 0; gi < FILTER_LEN; gi++) begin : g_hist
      if (gi == 0) begin : g_head
        assign hist_next[gi] = sync_reg[1];
      end else begin : g_tail
        assign hist_next[gi] = hist_reg[gi-1];
      end
    end
  endgenerate

  // Synchronize the asynchronous pin and shift the sample history (idle bus is high)
  always_ff @(posedge clock50) begin
    if (reset) begin
      sync_reg <= 2'b11;
      hist_reg <= '1;
    end else begin
      sync_reg <= {sync_reg[0], pin_in};
      hist_reg <= hist_next;
    end
  end

  // Filtered level only changes once the whole history agrees
  always_comb begin
    level_next = level_reg;
    if (&hist_reg) begin
      level_next = 1'b1;
    end else if (~|hist_reg) begin
      level_next = 1'b0;
    end
  end

  // Register the filtered level together with its edge pulses
  always_ff @(posedge clock50) begin
    if (reset) begin
      level_reg <= 1'b1;
      fall_reg  <= 1'b0;
      rise_reg  <= 1'b0;
    end else begin
      level_reg <= level_next;
      fall_reg  <= level_reg & ~level_next;
      rise_reg  <= ~level_reg & level_next;
    end
  end

  assign level = level_reg;
  assign fall  = fall_reg;
  assign rise  = rise_reg;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the clock, issues the
// request-to-send start bit, shifts out data/parity/stop on device clock
// falls, then checks the device ACK bit. Pins are driven open-drain via *_oe.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES    = 5000,
  parameter int REQ_CYCLES        = 250,
  parameter int FIRST_CLK_TIMEOUT = 750000,
  parameter int BIT_TIMEOUT       = 100000,
  parameter int FILTER_LEN        = 8
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_error
);

  localparam logic [CNT_W-1:0]    INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0]    REQ_LAST     = CNT_W'(REQ_CYCLES - 1);
  localparam logic [CNT_W-1:0]    FIRST_LOAD   = CNT_W'(FIRST_CLK_TIMEOUT);
  localparam logic [CNT_W-1:0]    BIT_LOAD     = CNT_W'(BIT_TIMEOUT);
  localparam logic [CNT_W-1:0]    WDOG_LAST    = CNT_W'(1);
  localparam logic [BITCNT_W-1:0] LAST_BIT     = BITCNT_W'(9);

  ps2_tx_state_t        state_reg, state_next;
  logic [9:0]           shift_reg, shift_next;
  logic [CNT_W-1:0]     phase_reg, phase_next;
  logic [CNT_W-1:0]     wdog_reg, wdog_next;
  logic [BITCNT_W-1:0]  bitcnt_reg, bitcnt_next;
  logic                 clk_oe_reg, clk_oe_next;
  logic                 dat_oe_reg, dat_oe_next;
  logic                 tx_ready_reg, busy_reg, tx_done_reg, tx_error_reg;
  logic [1:0]           dat_sync_reg;
  logic                 dat_sync;
  logic                 clk_level, clk_fall, clk_rise;

  ps2_clk_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_clk_filter (
    .clock50(CLOCK_50),
    .reset  (reset),
    .pin_in (ps2_clk_in),
    .level  (clk_level),
    .fall   (clk_fall),
    .rise   (clk_rise)
  );

  // Data pin only needs metastability protection; it is sampled on clock falls
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      dat_sync_reg <= 2'b11;
    end else begin
      dat_sync_reg <= {dat_sync_reg[0], ps2_dat_in};
    end
  end
  assign dat_sync = dat_sync_reg[1];

  // Next-state, datapath and line-drive decode; counters saturate instead of wrapping
  always_comb begin
    state_next  = state_reg;
    shift_next  = shift_reg;
    phase_next  = phase_reg;
    wdog_next   = wdog_reg;
    bitcnt_next = bitcnt_reg;
    dat_oe_next = dat_oe_reg;
    case (state_reg)
      IDLE: begin
        if (tx_valid && tx_ready_reg) begin
          shift_next = {1'b1, odd_parity(tx_data), tx_data};
          phase_next = '0;
          state_next = INHIBIT;
        end
      end
      INHIBIT: begin
        if (phase_reg >= INHIBIT_LAST) begin
          phase_next = '0;
          state_next = REQ;
        end else if (phase_reg != '1) begin
          phase_next = phase_reg + 1'b1;
        end
      end
      REQ: begin
        if (phase_reg >= REQ_LAST) begin
          wdog_next   = FIRST_LOAD;
          bitcnt_next = '0;
          state_next  = SEND;
        end else if (phase_reg != '1) begin
          phase_next = phase_reg + 1'b1;
        end
      end
      SEND: begin
        // A fall arriving on the expiry cycle still counts as progress
        if (clk_fall) begin
          dat_oe_next = ~shift_reg[0];
          shift_next  = {1'b0, shift_reg[9:1]};
          wdog_next   = BIT_LOAD;
          if (bitcnt_reg != '1) begin
            bitcnt_next = bitcnt_reg + 1'b1;
          end
          if (bitcnt_reg == LAST_BIT) begin
            state_next = ACK;
          end
        end else if (wdog_reg <= WDOG_LAST) begin
          state_next = ERR;
        end else begin
          wdog_next = wdog_reg - 1'b1;
        end
      end
      ACK: begin
        if (clk_fall) begin
          if (!dat_sync) begin
            wdog_next  = BIT_LOAD;
            state_next = WAIT_IDLE;
          end else begin
            state_next = ERR;
          end
        end else if (wdog_reg <= WDOG_LAST) begin
          state_next = ERR;
        end else begin
          wdog_next = wdog_reg - 1'b1;
        end
      end
      WAIT_IDLE: begin
        // Device releasing its clock after the ACK bit is progress too
        if (clk_level && dat_sync) begin
          state_next = DONE;
        end else if (clk_rise) begin
          wdog_next = BIT_LOAD;
        end else if (wdog_reg <= WDOG_LAST) begin
          state_next = ERR;
        end else begin
          wdog_next = wdog_reg - 1'b1;
        end
      end
      DONE:    state_next = IDLE;
      ERR:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
    // Clock is only ever pulled before the device takes over; data only in REQ/SEND
    clk_oe_next = (state_next == INHIBIT) || (state_next == REQ);
    if (state_next == REQ) begin
      dat_oe_next = 1'b1;
    end else if (state_next != SEND) begin
      dat_oe_next = 1'b0;
    end
  end

  // State and registered outputs, all derived from the next state
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_reg    <= IDLE;
      shift_reg    <= '0;
      phase_reg    <= '0;
      wdog_reg     <= '0;
      bitcnt_reg   <= '0;
      clk_oe_reg   <= 1'b0;
      dat_oe_reg   <= 1'b0;
      tx_ready_reg <= 1'b1;
      busy_reg     <= 1'b0;
      tx_done_reg  <= 1'b0;
      tx_error_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      shift_reg    <= shift_next;
      phase_reg    <= phase_next;
      wdog_reg     <= wdog_next;
      bitcnt_reg   <= bitcnt_next;
      clk_oe_reg   <= clk_oe_next;
      dat_oe_reg   <= dat_oe_next;
      tx_ready_reg <= (state_next == IDLE);
      busy_reg     <= (state_next != IDLE);
      tx_done_reg  <= (state_next == DONE);
      tx_error_reg <= (state_next == ERR);
    end
  end

  assign ps2_clk_oe = clk_oe_reg;
  assign ps2_dat_oe = dat_oe_reg;
  assign tx_ready   = tx_ready_reg;
  assign busy       = busy_reg;
  assign tx_done    = tx_done_reg;
  assign tx_error   = tx_error_reg;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a keyboard model clocks the frame out, a scoreboard
// queue holds the expected outcome of each request and a monitor checks it.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int INH      = 50;
  localparam int REQC     = 10;
  localparam int FIRST_TO = 3000;
  localparam int BIT_TO   = 1000;
  localparam int FLEN     = 8;
  localparam int HALF     = 100;

  logic       CLOCK_50 = 1'b0;
  logic       reset    = 1'b1;
  logic [7:0] tx_data  = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, ps2_clk_oe, ps2_dat_oe, busy, tx_done, tx_error;
  logic       ps2_clk_in, ps2_dat_in;
  logic       dev_clk_low = 1'b0;
  logic       dev_dat_low = 1'b0;

  // Open-drain bus with pull-ups
  assign ps2_clk_in = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_dat_in = ~(ps2_dat_oe | dev_dat_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES   (INH),
    .REQ_CYCLES       (REQC),
    .FIRST_CLK_TIMEOUT(FIRST_TO),
    .BIT_TIMEOUT      (BIT_TO),
    .FILTER_LEN       (FLEN)
  ) dut (
    .CLOCK_50  (CLOCK_50),
    .reset     (reset),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .ps2_clk_in(ps2_clk_in),
    .ps2_dat_in(ps2_dat_in),
    .ps2_clk_oe(ps2_clk_oe),
    .ps2_dat_oe(ps2_dat_oe),
    .busy      (busy),
    .tx_done   (tx_done),
    .tx_error  (tx_error)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int cyc = 0;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int release_cyc = 0;
  int last_fall_cyc = 0;
  logic [9:0] cap_bits = '0;

  typedef struct {
    bit         is_err;
    logic [9:0] frame;
    logic [7:0] data;
  } exp_t;
  exp_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d..%0d", name, act, lo, hi);
    end
  endtask

  // Scoreboard monitor: every done/error pulse consumes one expected entry
  logic pulse_prev = 1'b0;
  always @(negedge CLOCK_50) begin : monitor
    exp_t e;
    if (pulse_prev) begin
      check("pulse_width", {30'd0, tx_done, tx_error}, 0);
      check("ready_after_pulse", tx_ready, 1);
    end
    if (!reset && (tx_done || tx_error)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: done=%0b error=%0b required no pulse", tx_done, tx_error);
      end else begin
        e = exp_q.pop_front();
        check("resp_error", tx_error, e.is_err);
        check("resp_done", tx_done, !e.is_err);
        if (tx_done) check("frame_bits", cap_bits, e.frame);
        if (tx_error) check("oe_released", {30'd0, ps2_clk_oe, ps2_dat_oe}, 0);
        $display("txn 0x%02h: %s frame=%b", e.data, tx_done ? "done" : "error", cap_bits);
      end
      pulse_prev <= 1'b1;
    end else begin
      pulse_prev <= 1'b0;
    end
  end

  task automatic issue(input logic [7:0] d, input bit exp_err, input bit exp_par, input bit push);
    exp_t e;
    if (push) begin
      e.is_err = exp_err;
      e.frame  = {1'b1, exp_par, d};
      e.data   = d;
      exp_q.push_back(e);
    end
    @(negedge CLOCK_50);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge CLOCK_50);
    tx_valid = 1'b0;
  endtask

  // Measures clock-inhibit and request phases; returns at the negedge the clock is released
  task automatic host_request_check();
    int n;
    n = 0;
    while (!ps2_clk_oe && n < 100) begin
      @(negedge CLOCK_50);
      n++;
    end
    if (!ps2_clk_oe) begin
      checks++;
      errors++;
      $display("FAIL inhibit_start: clk_oe=0 after %0d cycles, required 1", n);
      return;
    end
    check("busy_ready_in_txn", {30'd0, busy, tx_ready}, 2);
    n = 0;
    while (!ps2_dat_oe && ps2_clk_oe && n < INH + 100) begin
      @(negedge CLOCK_50);
      n++;
    end
    check("inhibit_len", n, INH);
    n = 0;
    while (ps2_clk_oe && n < REQC + 100) begin
      @(negedge CLOCK_50);
      n++;
    end
    check("req_len", n, REQC);
    check("start_bit", ps2_dat_oe, 1);
    release_cyc = cyc;
  endtask

  // Keyboard model: generates nfalls clock pulses, samples data on rises
  task automatic device(input int nfalls, input bit ack);
    cap_bits = '0;
    for (int i = 1; i <= nfalls; i++) begin
      if (i == 11) dev_dat_low = ack;
      repeat (HALF) @(negedge CLOCK_50);
      dev_clk_low   = 1'b1;
      last_fall_cyc = cyc;
      repeat (HALF) @(negedge CLOCK_50);
      dev_clk_low = 1'b0;
      if (i <= 10) cap_bits[i-1] = ps2_dat_in;
    end
    if (nfalls >= 11) begin
      repeat (20) @(negedge CLOCK_50);
      dev_dat_low = 1'b0;
    end
  endtask

  task automatic settle();
    int n;
    n = 0;
    while (!(tx_ready && !busy) && n < 3 * BIT_TO) begin
      @(negedge CLOCK_50);
      n++;
    end
    if (!(tx_ready && !busy)) begin
      checks++;
      errors++;
      $display("FAIL settle: tx_ready=%0b busy=%0b, required 1/0", tx_ready, busy);
    end
    repeat (5) @(negedge CLOCK_50);
  endtask

  task automatic wait_pulse(input int limit, output int at);
    int n;
    n = 0;
    while (!(tx_done || tx_error) && n < limit) begin
      @(negedge CLOCK_50);
      n++;
    end
    at = cyc;
    if (!(tx_done || tx_error)) begin
      checks++;
      errors++;
      $display("FAIL pulse_wait: no done/error within %0d cycles", limit);
    end
  endtask

  typedef struct {
    logic [7:0] d;
    bit         par;
  } vec_t;

  vec_t vecs[5] = '{
    '{CMD_SET_LEDS, 1'b1},
    '{8'h01,        1'b0},
    '{8'h00,        1'b1},
    '{CMD_ENABLE,   1'b0},
    '{CMD_RESET,    1'b1}
  };

  initial begin
    int at;
    int n;
    reset = 1'b1;
    repeat (3) @(negedge CLOCK_50);
    reset = 1'b0;
    @(negedge CLOCK_50);
    check("reset_state", {26'd0, ps2_clk_oe, ps2_dat_oe, tx_ready, busy, tx_done, tx_error}, 6'b001000);

    // Normal transfers with ACK
    for (int i = 0; i < 5; i++) begin
      issue(vecs[i].d, 1'b0, vecs[i].par, 1'b1);
      host_request_check();
      if (i == 1) begin
        // A request during an active transfer must be ignored
        @(negedge CLOCK_50);
        tx_data  = 8'hAA;
        tx_valid = 1'b1;
        @(negedge CLOCK_50);
        tx_valid = 1'b0;
      end
      device(11, 1'b1);
      settle();
      if (i == 1) begin
        n = 0;
        repeat (INH + REQC + 20) begin
          @(negedge CLOCK_50);
          if (ps2_clk_oe) n++;
        end
        check("no_second_tx", n, 0);
      end
    end

    // NACK: data left high on the 11th clock
    issue(8'hED, 1'b1, 1'b1, 1'b1);
    host_request_check();
    device(11, 1'b0);
    settle();

    // No device: first-clock watchdog
    issue(8'hED, 1'b1, 1'b1, 1'b1);
    host_request_check();
    wait_pulse(FIRST_TO + 200, at);
    check_range("first_clk_timeout", at - release_cyc, FIRST_TO - (FLEN + 3), FIRST_TO + (FLEN + 3));
    settle();

    // Device stops after the 4th fall: bit watchdog
    issue(8'h01, 1'b1, 1'b0, 1'b1);
    host_request_check();
    device(4, 1'b1);
    wait_pulse(BIT_TO + 200, at);
    check_range("bit_timeout", at - last_fall_cyc, BIT_TO, BIT_TO + FLEN + 6);
    settle();

    // Reset after the 4th fall, with a stray request during the transfer
    issue(8'h00, 1'b0, 1'b1, 1'b0);
    host_request_check();
    device(4, 1'b1);
    check("dat_driven_before_reset", ps2_dat_oe, 1);
    @(negedge CLOCK_50);
    tx_data  = 8'h55;
    tx_valid = 1'b1;
    @(negedge CLOCK_50);
    tx_valid = 1'b0;
    reset    = 1'b1;
    @(negedge CLOCK_50);
    check("reset_mid", {28'd0, ps2_clk_oe, ps2_dat_oe, tx_ready, busy}, 4'b0010);
    reset = 1'b0;
    n = 0;
    repeat (INH + REQC + 50) begin
      @(negedge CLOCK_50);
      if (ps2_clk_oe || tx_done || tx_error) n++;
    end
    check("quiet_after_reset", n, 0);

    check("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    repeat (80000) @(posedge CLOCK_50);
    $display("FAIL global_timeout: run exceeded 80000 cycles, required completion");
    $fatal(1, "cycle budget exhausted");
  end

endmodule
